// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop sync, mid-bit sampling, one-entry valid/ready holding register.
// Optional parity check (PARITY state, parity_err_o) is built when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int CLKS_PER_TICK = 27
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD  = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 framing_err_o,
  output logic                 overrun_err_o,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err_o,
`endif
  output logic                 busy_o
);

  localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CLK_END = CW'(CLKS_PER_TICK - 1);
  localparam logic [TW-1:0] TC_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TC_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BI_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic                 rx_m_q, rx_s_q;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 tick;
  logic                 par_bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      oerr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      rx_m_q     <= rx_i;
      rx_s_q     <= rx_m_q;
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      oerr_q     <= oerr_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    oerr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
    par_bad    = ((^shift_q) ^ par_q) != PARITY_ODD;
`else
    par_bad    = 1'b0;
`endif

    tick = (state_q != IDLE) && (clk_cnt_q == CLK_END);

    // Tick phase is frozen in IDLE so sampling aligns to the detected start edge.
    if (state_q == IDLE) begin
      clk_cnt_d = '0;
    end else if (tick) begin
      clk_cnt_d = '0;
    end else begin
      clk_cnt_d = clk_cnt_q + 1'b1;
    end

    if (tick) begin
      tick_cnt_d = (tick_cnt_q == TC_END) ? '0 : tick_cnt_q + 1'b1;
    end

    if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        if (!rx_s_q) begin
          state_d = START;
        end
      end
      START: begin
        if (tick && tick_cnt_q == TC_MID) begin
          tick_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && tick_cnt_q == TC_END) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == BI_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && tick_cnt_q == TC_END) begin
          par_d   = rx_s_q;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // Leave at mid stop bit so a start edge half a bit later is still caught.
        if (tick && tick_cnt_q == TC_END) begin
          state_d = IDLE;
          ferr_d  = !rx_s_q;
`ifdef UART_RX_PARITY_EN
          perr_d  = par_bad;
`endif
          if (rx_s_q && !par_bad) begin
            if (!valid_q || rx_ready_i) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              oerr_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign framing_err_o = ferr_q;
  assign overrun_err_o = oerr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o  = perr_q;
`endif
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized + directed bench for uart_rx; scoreboard of expected bytes popped on each host handshake.
module tb_uart_rx;
  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int CPT      = 4;
  localparam int BIT_CLKS = OS * CPT;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_i = 1'b1;
  logic [DB-1:0] rx_data_o;
  logic          rx_valid_o;
  logic          rx_ready_i = 1'b1;
  logic          framing_err_o;
  logic          overrun_err_o;
  logic          busy_o;
`ifdef UART_RX_PARITY_EN
  logic          parity_err_o;
`endif

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS), .CLKS_PER_TICK(CPT)) dut (
    .clk(clk),
    .reset(reset),
    .rx_i(rx_i),
    .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i),
    .framing_err_o(framing_err_o),
    .overrun_err_o(overrun_err_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;
  logic [DB-1:0] sb[$];
  int ferr_cnt = 0, oerr_cnt = 0, perr_cnt = 0;
  int exp_ferr = 0, exp_oerr = 0, exp_perr = 0;
  logic ferr_prev = 1'b0, oerr_prev = 1'b0, perr_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted byte must be the oldest expected one.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid_o && rx_ready_i) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rx_byte: got %0h expected no byte", rx_data_o);
        end else begin
          check("rx_byte", {24'h0, rx_data_o}, {24'h0, sb.pop_front()});
        end
      end
      if (framing_err_o) begin
        ferr_cnt++;
        check("ferr_width", {31'h0, ferr_prev}, 32'h0);
      end
      if (overrun_err_o) begin
        oerr_cnt++;
        check("oerr_width", {31'h0, oerr_prev}, 32'h0);
      end
`ifdef UART_RX_PARITY_EN
      if (parity_err_o) begin
        perr_cnt++;
        check("perr_width", {31'h0, perr_prev}, 32'h0);
      end
      perr_prev = parity_err_o;
`endif
      ferr_prev = framing_err_o;
      oerr_prev = overrun_err_o;
    end
  end

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop);
    rx_i = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_bad_parity(input logic [DB-1:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    drive_bit(~(^d));
    drive_bit(1'b1);
    rx_i = 1'b1;
  endtask
`endif

  task automatic check_errs(input string tag);
    check({tag, "_ferr_cnt"}, ferr_cnt, exp_ferr);
    check({tag, "_oerr_cnt"}, oerr_cnt, exp_oerr);
    check({tag, "_perr_cnt"}, perr_cnt, exp_perr);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_data"}, {24'h0, rx_data_o}, 32'h0);
    check({tag, "_valid"}, {31'h0, rx_valid_o}, 32'h0);
    check({tag, "_ferr"}, {31'h0, framing_err_o}, 32'h0);
    check({tag, "_oerr"}, {31'h0, overrun_err_o}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    int lat;
    logic [DB-1:0] b;

    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    idle(10);

    // 0xA5 with latency: sync(2) + detect(1) + (8 + 9*16) ticks * 4 clks = 611, +/-2 slack.
    sb.push_back(8'hA5);
    t0 = cyc;
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 800; i++) begin
          @(negedge clk);
          if (rx_valid_o) begin
            lat = int'(cyc - t0);
            break;
          end
        end
      end
    join
    check("latency_in_window", {31'h0, (lat >= 609 && lat <= 613)}, 32'h1);
    idle(50);
    check_errs("a5");

    // Short glitch must be rejected at start mid-bit.
    rx_i = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("glitch_busy_hi", {31'h0, busy_o}, 32'h1);
    repeat (10) @(posedge clk); #1;
    rx_i = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("glitch_busy_lo", {31'h0, busy_o}, 32'h0);
    check("glitch_valid", {31'h0, rx_valid_o}, 32'h0);
    check_errs("glitch");

    // Framing error then a good frame.
    send_frame(8'h3C, 1'b0);
    exp_ferr++;
    idle(100);
    check("ferr_valid", {31'h0, rx_valid_o}, 32'h0);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(50);
    check_errs("framing");

    // Overrun: host stalled, two back-to-back frames.
    rx_ready_i = 1'b0;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    exp_oerr++;
    idle(20);
    check("ovr_held_data", {24'h0, rx_data_o}, 32'h11);
    check("ovr_held_valid", {31'h0, rx_valid_o}, 32'h1);
    check_errs("overrun");
    rx_ready_i = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("ovr_drain_valid", {31'h0, rx_valid_o}, 32'h0);
    idle(50);

    // Accept on the exact stop-sample edge of frame 2 (611 edges after frame 2 starts at +640).
    rx_ready_i = 1'b0;
    sb.push_back(8'h6E);
    sb.push_back(8'h91);
    fork
      begin
        send_frame(8'h6E, 1'b1);
        send_frame(8'h91, 1'b1);
      end
      begin
        repeat (640 + 610) @(posedge clk);
        #1 rx_ready_i = 1'b1;
        @(posedge clk);
        #1 rx_ready_i = 1'b0;
      end
    join
    idle(5);
    check("simul_valid", {31'h0, rx_valid_o}, 32'h1);
    check("simul_data", {24'h0, rx_data_o}, 32'h91);
    check_errs("simul");
    rx_ready_i = 1'b1;
    idle(50);

    // Reset mid-frame with a byte held: both the frame and the held byte vanish.
    rx_ready_i = 1'b0;
    sb.push_back(8'h77);
    send_frame(8'h77, 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    reset = 1'b1;
    sb.delete();
    rx_i = 1'b1;
    repeat (2) @(posedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    rx_ready_i = 1'b1;
    idle(100);
    sb.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    idle(50);
    check_errs("c3");

`ifdef UART_RX_PARITY_EN
    send_bad_parity(8'h96);
    exp_perr++;
    idle(50);
    check("par_valid", {31'h0, rx_valid_o}, 32'h0);
    check_errs("parity");
`endif

    // Random bytes, random gaps, occasional bad stop bit.
    for (int n = 0; n < 16; n++) begin
      b = DB'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) begin
        send_frame(b, 1'b0);
        exp_ferr++;
        idle(70 + $urandom_range(0, 40));
      end else begin
        sb.push_back(b);
        send_frame(b, 1'b1);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 80));
      end
    end
    idle(100);
    check_errs("random");
    check("sb_empty", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receive stage of the UART. It consumes the line driven by the transmit FSM/shift-register path (start bit, LSB-first data, stop bit, line idle high). The line is oversampled, each bit is sampled at mid-bit, and every good byte goes to the host through a one-entry valid/ready holding register. Framing and overrun errors are flagged.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
OVERSAMPLE, 16, sample ticks per bit period (even, >=4)
CLKS_PER_TICK, 27, clk cycles per sample tick (>=1); bit period = OVERSAMPLE*CLKS_PER_TICK clks

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_i  input  1  asynchronous serial line, idle high
rx_data_o  output  DATA_BITS  received byte, LSB = first data bit
rx_valid_o  output  1  rx_data_o holds an unconsumed byte
rx_ready_i  input  1  host accepts the byte on a clk edge where rx_valid_o && rx_ready_i
framing_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_err_o  output  1  one-cycle pulse: good byte dropped because holding register full
busy_o  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (clk edge with reset=1): 2-flop synchronizer flops = 1, FSM = IDLE, all counters = 0, rx_data_o = 0, rx_valid_o = 0, both error pulses = 0, busy_o = 0. Reset mid-frame abandons the frame and clears any held byte.
- rx_i passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- Tick generator: counts 0..CLKS_PER_TICK-1. tick = (count == CLKS_PER_TICK-1). Held at 0 in IDLE, so phase aligns to start-edge detection.
- tick_cnt counts ticks within the current bit and is cleared on every state change.
- States:
  IDLE: rx_s == 0 -> START (tick and tick_cnt start at 0).
  START: on the tick where tick_cnt == OVERSAMPLE/2-1, sample rx_s. If 1 -> IDLE (glitch rejected, no flag). If 0 -> DATA, bit_idx = 0.
  DATA: on the tick where tick_cnt == OVERSAMPLE-1, shift rx_s into shift reg MSB-side (LSB-first assembly), bit_idx++. After DATA_BITS samples -> STOP (or PARITY under macro).
  STOP: on the tick where tick_cnt == OVERSAMPLE-1, sample rx_s and go to IDLE on the same edge. 0 -> framing_err_o pulses, byte discarded. 1 -> deliver.
- Return to IDLE at stop mid-bit, so a start edge half a bit later is caught. Back-to-back frames are supported.
- Deliver on the same edge as the stop sample:
  - rx_valid_o == 0, or rx_ready_i == 1 on that edge (simultaneous accept): load rx_data_o, set rx_valid_o = 1, no overrun.
  - Otherwise: keep the old byte, drop the new one, pulse overrun_err_o.
- rx_valid_o clears on a handshake edge with no simultaneous load. rx_data_o is stable while rx_valid_o = 1.
- Latency: from the first clk where rx_s = 0, rx_valid_o rises after ((DATA_BITS+1)*OVERSAMPLE + OVERSAMPLE/2)*CLKS_PER_TICK clks (+/-1). The synchronizer adds 2 clks from rx_i.
- Error pulses last exactly one clk. A framing error never sets rx_valid_o.

Optional Feature:
UART_RX_PARITY_EN
- Defined: adds parameter PARITY_ODD (default 0 = even), a PARITY state between DATA and STOP (one full bit, sampled at tick_cnt == OVERSAMPLE-1), and output parity_err_o (1 bit, one-cycle pulse at the stop sample). A frame with a parity mismatch and a good stop bit pulses parity_err_o and is not delivered. If both parity and stop are bad, both flags pulse.
- Undefined: no PARITY state, no parity_err_o port. The frame is start + DATA_BITS + stop.

Test Plan:
- Defaults except CLKS_PER_TICK=4 (64 clk/bit); drive 0xA5 frame with rx_ready_i=1 -> rx_data_o=0xA5, rx_valid_o high ~610 clks after line falls, no error pulses.
- 20-clk low glitch on idle line -> FSM back to IDLE by clk ~35, busy_o low, no rx_valid_o or error pulse.
- Frame 0x3C with stop bit driven 0 -> framing_err_o pulses 1 clk, rx_valid_o stays 0; following good frame 0x5A is received correctly.
- rx_ready_i=0; frames 0x11 then 0x22 back-to-back -> rx_data_o=0x11 held, overrun_err_o pulses at 0x22 stop; raising rx_ready_i clears rx_valid_o next edge.
- rx_ready_i asserted exactly on the stop-sample edge of frame 2 while frame 1 is held -> frame 1 accepted, rx_data_o = frame 2, rx_valid_o stays 1, no overrun.
- Reset pulse mid-data-bits, then full frame 0xC3 -> all outputs 0 after reset, 0xC3 received. With UART_RX_PARITY_EN, even parity, wrong parity bit -> parity_err_o pulse, no valid.
